point_serializer: RTL and testbench
===================================

// Module: point_serializer
// PURPOSE
//  Transmit end of the point datapath: takes one affine secp256k1 point (e.g. x3/y3 from point_add)
//  and emits its SEC1 encoding as a byte stream, MSB first. Compressed = 33 B, uncompressed = 65 B,
//  point-at-infinity = 1 B (0x00). Coordinates >= p are rejected with an error pulse and no bytes.
// PARAMETERS
//  COORD_W   256   coordinate width in bits; must be a multiple of 8
//  BYTE_W    8     output symbol width
// PORTS
//  clk          in   1        rising-edge clock
//  reset_n      in   1        asynchronous, active-low reset
//  in_valid     in   1        point presented
//  in_ready     out  1        serializer can accept a point
//  in_x         in   COORD_W  affine x
//  in_y         in   COORD_W  affine y
//  in_inf       in   1        point is infinity; in_x/in_y ignored
//  in_compress  in   1        1 = compressed (02/03 || X), 0 = uncompressed (04 || X || Y)
//  out_valid    out  1        out_data valid
//  out_ready    in   1        sink accepts byte
//  out_data     out  BYTE_W   encoded byte
//  out_last     out  1        final byte of the current encoding
//  busy         out  1        high in every state except IDLE
//  err_range    out  1        one-cycle pulse: in_x >= p or in_y >= p
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_last=0;
//   busy=0; err_range=0; point and count regs cleared.
//  States: IDLE -> CHECK -> {PREFIX -> XBYTES -> [YBYTES]} | INF | IDLE(error).
//  IDLE: in_ready=1. Handshake in_valid&&in_ready at edge T latches x,y,inf,compress; in_ready=0 from T.
//  CHECK (cycle T+1): inf -> INF; else if x>=p or y>=p -> err_range=1 for this cycle, then IDLE,
//   no out_valid. Otherwise -> PREFIX. The y check applies in compressed mode too.
//  First out_valid appears at cycle T+2: fixed 2-cycle latency to the first byte.
//  INF: out_data=0x00, out_last=1. PREFIX: compressed: 0x02|y[0]; uncompressed: 0x04.
//  XBYTES: COORD_W/8 bytes of x, MSB first. YBYTES is uncompressed mode only: same for y.
//  out_last=1 only on INF, on the final x byte (compressed), and on the final y byte (uncompressed).
//  Output handshake: a byte moves on out_valid&&out_ready. While out_valid&&!out_ready,
//   out_data/out_last are held stable and out_valid stays high. out_valid never depends on out_ready.
//  With out_ready tied to 1: one byte per cycle, no bubbles within a frame.
//  After the last-byte handshake: IDLE next cycle, in_ready=1. Next accept is possible 1 cycle after the last byte.
//  Byte counter: 6 bits, resets per field, compared to COORD_W/8-1. Shift register shifts left by 8 per beat.
//  Range compare: unsigned COORD_W-bit compare against the constant p.
//   p = FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFF FFFFFFFE FFFFFC2F.
//  in_x/in_y are sampled only at accept; later changes have no effect.
//  reset_n low mid-frame: immediate abort, out_valid=0 asynchronously, no resume. The sink sees a truncated frame.
//  in_valid while busy: ignored; in_ready stays 0 and nothing is latched.
// STRUCTURE
//  Shared secp256k1_pkg (header secp256k1_defs.vh): SECP_P, SEC1 prefix constants (PFX_INF=00,
//   PFX_EVEN=02, PFX_ODD=03, PFX_UNC=04), state encodings. point_add consumes the same SECP_P.
//  One sub-module: secp_range_check (combinational, x,y -> in_range). Reused later by the decoder.
//  FSM, counter, shift register and output register live in point_serializer.
// TESTING
//  G, compressed, out_ready=1 -> 33 bytes: 02 79 BE 66 7E ... 16 F8 17 98. out_last on byte 33.
//   First out_valid exactly 2 cycles after accept. Gx=79BE667E...16F81798, Gy even.
//  G, uncompressed -> 65 bytes: 04, Gx bytes, then 48 3A DA 77 ... FB 10 D4 B8. out_last only on byte 65.
//  Odd y (y=Gy+1 mod p is fine for the encoder), compressed -> first byte 03.
//  in_inf=1 (x,y = all ones) -> single byte 00 with out_last=1. err_range stays 0.
//  x = p, y = Gy -> err_range pulse at T+1, zero out_valid beats, in_ready=1 at T+2.
//   Repeat with x = p-1, y = p -> same pulse.
//  Random out_ready (50%) on G uncompressed -> identical 65-byte sequence.
//   out_data/out_last never change while stalled.
//  reset_n low during byte 10 -> out_valid=0 immediately. After release, accept G compressed -> fresh 33-byte frame from 02.

Source files
------------

// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 constants: field prime, SEC1 prefix bytes and serializer state encoding.
package secp256k1_pkg;

  localparam logic [255:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  localparam logic [7:0] PFX_INF  = 8'h00;
  localparam logic [7:0] PFX_EVEN = 8'h02;
  localparam logic [7:0] PFX_ODD  = 8'h03;
  localparam logic [7:0] PFX_UNC  = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StInf,
    StPrefix,
    StXBytes,
    StYBytes
  } ser_state_e;

endpackage

// File: rtl/secp_range_check.sv
// Combinational field-range check: both coordinates must be strictly below p.
module secp_range_check
  import secp256k1_pkg::*;
#(
  parameter int unsigned COORD_W = 256
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               in_range
);

  localparam logic [COORD_W-1:0] P = SECP_P[COORD_W-1:0];

  assign in_range = (x < P) && (y < P);

endmodule

// File: rtl/point_serializer.sv
// SEC1 encoder for an affine secp256k1 point: emits prefix, X and optionally Y bytes MSB first.
module point_serializer
  import secp256k1_pkg::*;
#(
  parameter int unsigned COORD_W = 256,
  parameter int unsigned BYTE_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic               in_inf,
  input  logic               in_compress,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err_range
);

  localparam int unsigned NBytes  = COORD_W / BYTE_W;
  localparam logic [5:0]  LastIdx = 6'(NBytes - 1);

  ser_state_e         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               inf_q, inf_d, comp_q, comp_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               in_range, accept, fire, cnt_last;

  secp_range_check #(
    .COORD_W (COORD_W)
  ) u_range (
    .x        (x_q),
    .y        (y_q),
    .in_range (in_range)
  );

  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;
  assign cnt_last = (cnt_q == LastIdx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StCheck;
      StCheck: begin
        if (inf_q)          state_d = StInf;
        else if (!in_range) state_d = StIdle;
        else                state_d = StPrefix;
      end
      StInf:    if (out_ready) state_d = StIdle;
      StPrefix: if (out_ready) state_d = StXBytes;
      StXBytes: if (out_ready && cnt_last) state_d = comp_q ? StIdle : StYBytes;
      StYBytes: if (out_ready && cnt_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = (state_q != StIdle);
    err_range = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StCheck: err_range = !inf_q && !in_range;
      StInf: begin
        out_valid = 1'b1;
        out_data  = BYTE_W'(PFX_INF);
        out_last  = 1'b1;
      end
      StPrefix: begin
        out_valid = 1'b1;
        out_data  = comp_q ? BYTE_W'(y_q[0] ? PFX_ODD : PFX_EVEN) : BYTE_W'(PFX_UNC);
      end
      StXBytes: begin
        out_valid = 1'b1;
        out_data  = x_q[COORD_W-1 -: BYTE_W];
        out_last  = comp_q && cnt_last;
      end
      StYBytes: begin
        out_valid = 1'b1;
        out_data  = y_q[COORD_W-1 -: BYTE_W];
        out_last  = cnt_last;
      end
      default: ;
    endcase
  end

  // Coordinates shift left so the current byte always sits in the top BYTE_W bits.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    inf_d  = inf_q;
    comp_d = comp_q;
    cnt_d  = cnt_q;
    if (accept) begin
      x_d    = in_x;
      y_d    = in_y;
      inf_d  = in_inf;
      comp_d = in_compress;
      cnt_d  = '0;
    end else if (fire && state_q == StXBytes) begin
      x_d   = x_q << BYTE_W;
      cnt_d = cnt_last ? 6'd0 : cnt_q + 6'd1;
    end else if (fire && state_q == StYBytes) begin
      y_d   = y_q << BYTE_W;
      cnt_d = cnt_last ? 6'd0 : cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      inf_q  <= 1'b0;
      comp_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      inf_q  <= inf_d;
      comp_q <= comp_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_point_serializer.sv
// Directed bench for point_serializer: G frames, odd y, infinity, range errors, stalls, abort.
module tb_point_serializer;

  localparam logic [255:0] GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] PRIME =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, in_inf, in_compress;
  logic [255:0] in_x, in_y;
  logic         out_valid, out_ready, out_last, busy, err_range;
  logic [7:0]   out_data;

  int n_cmp = 0;
  int n_err = 0;
  int stall_viol = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  point_serializer #(
    .COORD_W (256),
    .BYTE_W  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_inf      (in_inf),
    .in_compress (in_compress),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err_range   (err_range)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input logic [255:0] x, input logic [255:0] y, input logic inf,
                           input logic comp);
    exp_q.delete();
    if (inf) begin
      exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back(comp ? (y[0] ? 8'h03 : 8'h02) : 8'h04);
      for (int i = 0; i < 32; i++) exp_q.push_back(x[255-8*i -: 8]);
      if (!comp) for (int i = 0; i < 32; i++) exp_q.push_back(y[255-8*i -: 8]);
    end
  endtask

  // Presents one point, checks the CHECK cycle and the cycle after it.
  task automatic send(input logic [255:0] x, input logic [255:0] y, input logic inf,
                      input logic comp, input bit exp_err);
    in_x = x; in_y = y; in_inf = inf; in_compress = comp; in_valid = 1'b1;
    check("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = ~x; in_y = ~y; in_inf = ~inf; in_compress = ~comp;
    check("chk_in_ready", in_ready, 0);
    check("chk_busy", busy, 1);
    check("chk_out_valid", out_valid, 0);
    check("chk_err_range", err_range, exp_err);
    @(posedge clk); #1;
    check("t2_err_range", err_range, 0);
    check("t2_out_valid", out_valid, !exp_err);
    check("t2_in_ready", in_ready, exp_err);
  endtask

  // Drains one frame against exp_q; abort_at >= 0 pulls reset while that byte index is shown.
  task automatic collect(input bit rnd, input int abort_at);
    int n, guard;
    bit done, held;
    logic [7:0] hd;
    logic hl;
    n = 0; guard = 0; done = 0; held = 0; hd = '0; hl = 1'b0;
    while (!done && guard < 2000) begin
      if (held && (out_valid !== 1'b1 || out_data !== hd || out_last !== hl)) stall_viol++;
      if (abort_at == n && out_valid) begin
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        done = 1;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        held = out_valid && !out_ready;
        hd = out_data;
        hl = out_last;
        if (out_valid && out_ready) begin
          check($sformatf("byte%0d", n), out_data, n < exp_q.size() ? exp_q[n] : 8'hxx);
          check($sformatf("last%0d", n), out_last, n == exp_q.size() - 1);
          n++;
          if (out_last || n >= exp_q.size()) done = 1;
        end
        @(posedge clk); #1;
        guard++;
      end
    end
    if (abort_at < 0) begin
      check("frame_len", n, exp_q.size());
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
      check("post_out_valid", out_valid, 0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    in_inf = 1'b0; in_compress = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err_range", err_range, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    build_exp(GX, GY, 1'b0, 1'b1);
    send(GX, GY, 1'b0, 1'b1, 1'b0);
    collect(1'b0, -1);

    build_exp(GX, GY, 1'b0, 1'b0);
    send(GX, GY, 1'b0, 1'b0, 1'b0);
    collect(1'b0, -1);

    build_exp(GX, GY + 256'd1, 1'b0, 1'b1);
    send(GX, GY + 256'd1, 1'b0, 1'b1, 1'b0);
    collect(1'b0, -1);

    build_exp('1, '1, 1'b1, 1'b0);
    send('1, '1, 1'b1, 1'b0, 1'b0);
    collect(1'b0, -1);

    send(PRIME, GY, 1'b0, 1'b1, 1'b1);
    check("err1_busy", busy, 0);
    send(PRIME - 256'd1, PRIME, 1'b0, 1'b0, 1'b1);
    check("err2_busy", busy, 0);

    build_exp(GX, GY, 1'b0, 1'b0);
    send(GX, GY, 1'b0, 1'b0, 1'b0);
    collect(1'b1, -1);
    check("stall_hold_viol", stall_viol, 0);

    build_exp(GX, GY, 1'b0, 1'b1);
    send(GX, GY, 1'b0, 1'b1, 1'b0);
    collect(1'b0, 9);
    @(posedge clk); #1;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_data", out_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send(GX, GY, 1'b0, 1'b1, 1'b0);
    collect(1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
